booth_r4_ctrl: RTL and testbench

Sequencing controller for the radix-4 Booth multiplier datapath. Accepts a start request, loads the operand shift register and clears the accumulator, then runs WIDTH/2 iterations. Each iteration decodes the current Booth triplet into partial-product controls and shifts the multiplier register right by two positions. Sits between the requesting logic and the `register`/accumulator/adder datapath and drives all of their enables.

---
 rtl/booth_r4_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_booth_r4_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/booth_r4_ctrl.sv
// ---------------------------------------------------------------------------
// booth_r4_ctrl
// Sequencing controller for a radix-4 Booth multiplier datapath. A start
// request loads the operand shift register and clears the accumulator, then
// WIDTH/2 iterations follow. Each iteration is EVAL (decode the Booth triplet
// into partial-product controls), SH1 and SH2 (shift the multiplier register
// right by one position each). DONE pulses for one cycle at the end.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        multiply request, accepted only while ready=1
//   ready        controller idle
//   booth_bits   {q[1], q[0], q_m1} from the multiplier register
//   load_en      load operands into the shift register
//   acc_clr      synchronous accumulator clear
//   acc_en       accumulator captures accumulator + partial product
//   pp_neg       partial product negated
//   pp_dbl       partial product is 2M (else M)
//   shift_en     shift multiplier register right by one
//   iter         remaining iterations (observation)
//   done         one-cycle completion pulse
//   abort        cancel a running operation (BOOTH_CTRL_ABORT_EN only)
//
// Build option
//   BOOTH_CTRL_ABORT_EN  adds the abort port; abort sampled in LOAD, EVAL,
//                        SH1 or SH2 returns the controller to IDLE with
//                        iter=0 and no done pulse.
//
// Outputs are decoded from the state register; only the EVAL
// partial-product controls also depend combinationally on booth_bits.
// WIDTH must be even and >= 4.
// ---------------------------------------------------------------------------
module booth_r4_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           ready,
  input  logic [2:0]                     booth_bits,
`ifdef BOOTH_CTRL_ABORT_EN
  input  logic                           abort,
`endif
  output logic                           load_en,
  output logic                           acc_clr,
  output logic                           acc_en,
  output logic                           pp_neg,
  output logic                           pp_dbl,
  output logic                           shift_en,
  output logic [$clog2(WIDTH/2+1)-1:0]   iter,
  output logic                           done
);

  localparam int unsigned N      = WIDTH / 2;
  localparam int unsigned ITER_W = $clog2(WIDTH / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EVAL = 3'd2,
    S_SH1  = 3'd3,
    S_SH2  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                abort_c;
  logic                busy_c;

  // Cancel request; tied off when the option is not built in
`ifdef BOOTH_CTRL_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Abort is honoured only while an operation is actually in progress
  assign busy_c = (state_q == S_LOAD) || (state_q == S_EVAL) ||
                  (state_q == S_SH1)  || (state_q == S_SH2);

  // State and iteration counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    ready    = 1'b0;
    load_en  = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    pp_neg   = 1'b0;
    pp_dbl   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        load_en = 1'b1;
        acc_clr = 1'b1;
        iter_d  = ITER_W'(N);
        state_d = S_EVAL;
      end

      S_EVAL: begin
        // Radix-4 Booth recoding of {q[1], q[0], q_m1}
        case (booth_bits)
          3'b001, 3'b010: begin
            acc_en = 1'b1;
          end
          3'b011: begin
            acc_en = 1'b1;
            pp_dbl = 1'b1;
          end
          3'b100: begin
            acc_en = 1'b1;
            pp_neg = 1'b1;
            pp_dbl = 1'b1;
          end
          3'b101, 3'b110: begin
            acc_en = 1'b1;
            pp_neg = 1'b1;
          end
          default: begin
            acc_en = 1'b0;
          end
        endcase
        state_d = S_SH1;
      end

      S_SH1: begin
        shift_en = 1'b1;
        state_d  = S_SH2;
      end

      S_SH2: begin
        shift_en = 1'b1;
        iter_d   = iter_q - ITER_W'(1);
        // iter_q still holds the pre-decrement count here
        if (iter_q == ITER_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EVAL;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        iter_d  = '0;
      end
    endcase

    if (abort_c && busy_c) begin
      state_d = S_IDLE;
      iter_d  = '0;
    end
  end

  assign iter = iter_q;

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_ctrl
// Directed bench for booth_r4_ctrl at WIDTH=8 (N=4). Each operation is
// walked cycle by cycle after the start-sampling edge E0; the expected
// output vector for every cycle comes from a cycle-position model of the
// sequence (LOAD, 4x{EVAL,SH1,SH2}, DONE, IDLE) and the Booth recoding table.
// ---------------------------------------------------------------------------
module tb_booth_r4_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = WIDTH / 2;
  localparam int          OPLEN = 3 * N + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [2:0] booth_bits;
  logic       abort;
  logic       load_en, acc_clr, acc_en, pp_neg, pp_dbl, shift_en, done;
  logic [2:0] iter;

  int n_checks = 0;
  int n_errors = 0;

  // {ready, load_en, acc_clr, acc_en, pp_neg, pp_dbl, shift_en, done, iter}
  logic [10:0] obs;
  assign obs = {ready, load_en, acc_clr, acc_en, pp_neg, pp_dbl, shift_en, done, iter};

  localparam logic [10:0] IDLE_VEC = 11'b1_0000000_000;

  booth_r4_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ready      (ready),
    .booth_bits (booth_bits),
`ifdef BOOTH_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .load_en    (load_en),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .pp_neg     (pp_neg),
    .pp_dbl     (pp_dbl),
    .shift_en   (shift_en),
    .iter       (iter),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {acc_en, pp_neg, pp_dbl} for a Booth triplet
  function automatic logic [2:0] booth_exp(input logic [2:0] bb);
    case (bb)
      3'b001, 3'b010: return 3'b100;
      3'b011:         return 3'b101;
      3'b100:         return 3'b111;
      3'b101, 3'b110: return 3'b110;
      default:        return 3'b000;
    endcase
  endfunction

  // Expected output vector for cycle cm (1..OPLEN) after E0
  function automatic logic [10:0] exp_vec(input int cm, input logic [2:0] bb);
    int k, ph;
    logic [2:0] it;
    if (cm == 1) return 11'b0_1100000_000;                 // LOAD
    if (cm == OPLEN - 1) return 11'b0_0000001_000;         // DONE
    if (cm >= OPLEN) return IDLE_VEC;
    k  = (cm - 2) / 3;
    ph = (cm - 2) % 3;
    it = 3'(N - k);
    if (ph == 0) return {4'b0000, booth_exp(bb), 1'b0, 1'b0, it};   // EVAL
    return {7'b0000001, 1'b0, it};                         // SH1 / SH2
  endfunction

  // One operation: start pulse (or held), per-cycle vector checks,
  // optional reset pulse or abort at a given cycle after E0.
  task automatic run_op(input string name, input logic [11:0] bbs, input int ncyc,
                        input int hold_to, input int rst_at, input int abort_at);
    int cm, k, ph;
    int n_load, n_shift, n_done, n_acc;
    logic [10:0] exp;
    n_load = 0; n_shift = 0; n_done = 0; n_acc = 0;
    @(negedge clk);
    start      = 1'b1;
    booth_bits = 3'b011;
    @(posedge clk);   // E0
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cm    = (c - 1) % OPLEN + 1;
      start = (c < hold_to);
      k     = (cm >= 2 && cm <= OPLEN - 2) ? (cm - 2) / 3 : -1;
      ph    = (cm >= 2) ? (cm - 2) % 3 : 0;
      // Iteration triplet held over EVAL/SH1/SH2; elsewhere a non-zero
      // pattern so any leak of the decode outside EVAL is visible.
      booth_bits = (k >= 0) ? bbs[3*k +: 3] : 3'b011;
      if (rst_at != 0 && c == rst_at)     rst_n = 1'b0;
      if (rst_at != 0 && c == rst_at + 1) rst_n = 1'b1;
      abort = (abort_at != 0 && c == abort_at);
      #1;
      if ((rst_at != 0 && c >= rst_at) || (abort_at != 0 && c > abort_at))
        exp = IDLE_VEC;
      else
        exp = exp_vec(cm, booth_bits);
      check($sformatf("%s_c%0d_ph%0d", name, c, ph), 32'(obs), 32'(exp));
      n_load  += int'(load_en);
      n_shift += int'(shift_en);
      n_done  += int'(done);
      n_acc   += int'(acc_en);
    end
    start = 1'b0;
    abort = 1'b0;
    if (rst_at == 0 && abort_at == 0) begin
      check({name, "_nload"},  32'(n_load),  32'(ncyc / OPLEN));
      check({name, "_nshift"}, 32'(n_shift), 32'(2 * N * (ncyc / OPLEN)));
      check({name, "_ndone"},  32'(n_done),  32'(ncyc / OPLEN));
    end else begin
      check({name, "_ndone"}, 32'(n_done), 32'd0);
    end
    if (bbs == 12'h000) check({name, "_nacc"}, 32'(n_acc), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    booth_bits = 3'b000;
    abort      = 1'b0;

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_hold", 32'(obs), 32'(IDLE_VEC));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel", 32'(obs), 32'(IDLE_VEC));

    // Triplet 000 throughout: no accumulation, 8 shifts, done at cycle 14
    run_op("zero", 12'h000, OPLEN, 0, 0, 0);

    // Iterations 011, 100, 101, 001 -> (1,0,1), (1,1,1), (1,1,0), (1,0,0)
    run_op("mix1", {3'b001, 3'b101, 3'b100, 3'b011}, OPLEN, 0, 0, 0);

    // Iterations 111, 010, 110, 000 -> (0,0,0), (1,0,0), (1,1,0), (0,0,0)
    run_op("mix2", {3'b000, 3'b110, 3'b010, 3'b111}, OPLEN, 0, 0, 0);

    // start held high: back-to-back operations, one done per 15 cycles
    run_op("hold", {3'b100, 3'b011, 3'b001, 3'b110}, 2 * OPLEN, 2 * OPLEN, 0, 0);

    // Reset pulse during the third EVAL (cycle 8 after E0)
    run_op("rstmid", {3'b011, 3'b011, 3'b011, 3'b011}, 20, 0, 8, 0);
    run_op("postrst", {3'b010, 3'b100, 3'b111, 3'b101}, OPLEN, 0, 0, 0);

`ifdef BOOTH_CTRL_ABORT_EN
    // Abort during SH1 of iteration 2 (cycle 6 after E0)
    run_op("abort", {3'b001, 3'b001, 3'b001, 3'b001}, 20, 0, 0, 6);
    run_op("postabort", {3'b110, 3'b001, 3'b011, 3'b100}, OPLEN, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
